// File: rtl/tag_rx_sched.sv
// tag_rx_sched: burst scheduler for the tag RX chain.
// Sequences arm / preamble search / sync lock / capture / guard gap bursts,
// owns the RX controller run enable and reports progress and timeouts.
module tag_rx_sched #(
    parameter int CNT_WIDTH   = 32,
    parameter int BURST_WIDTH = 8,
    parameter int TERR_WIDTH  = 16,
    parameter int GAP_LEN     = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [BURST_WIDTH-1:0] nbursts,
    input  logic [CNT_WIDTH-1:0]   capture_len,
    input  logic [CNT_WIDTH-1:0]   timeout_len,
    input  logic [1:0]             rx_state_in,
    output logic                   run_rx,
    output logic                   capture_en,
    output logic                   busy,
    output logic                   done,
    output logic                   timeout_err,
    output logic [BURST_WIDTH-1:0] burst_cnt,
    output logic [TERR_WIDTH-1:0]  timeout_cnt
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        SEARCH  = 3'd2,
        LOCK    = 3'd3,
        CAPTURE = 3'd4,
        GAP     = 3'd5
    } state_t;

    localparam logic [1:0] RX_INIT   = 2'b00;
    localparam logic [1:0] RX_SYNC   = 2'b01;
    localparam logic [1:0] RX_LOC_RX = 2'b11;

    // Guard gap shorter than 2 cycles would not let the controller settle in clear.
    localparam logic [CNT_WIDTH-1:0] GAP_LAST =
        (GAP_LEN < 2) ? CNT_WIDTH'(1) : CNT_WIDTH'(GAP_LEN - 1);

    state_t                 state;
    logic [CNT_WIDTH-1:0]   timer;
    logic [BURST_WIDTH-1:0] nb_q;
    logic [CNT_WIDTH-1:0]   cap_q;
    logic [CNT_WIDTH-1:0]   to_q;

    logic [CNT_WIDTH-1:0]   cap_last;
    logic                   to_hit;
    logic                   gap_end;
    logic                   seq_fin;

    // A zero capture length behaves as a single-cycle window.
    assign cap_last = (cap_q == '0) ? '0 : cap_q - CNT_WIDTH'(1);
    assign to_hit   = (to_q != '0) && (timer == to_q - CNT_WIDTH'(1));
    assign gap_end  = (timer == GAP_LAST);
    assign seq_fin  = (nb_q != '0) && (burst_cnt == nb_q);

    // Status outputs decode straight from the registered state.
    assign run_rx     = (state == ARM) || (state == SEARCH) ||
                        (state == LOCK) || (state == CAPTURE);
    assign capture_en = (state == CAPTURE);
    assign busy       = (state != IDLE);
    // done marks the final gap cycle; an abort on that cycle suppresses it.
    assign done       = (state == GAP) && gap_end && seq_fin && !abort;

    // Burst sequencing FSM; the timer restarts from zero on every state entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            timer       <= '0;
            nb_q        <= '0;
            cap_q       <= '0;
            to_q        <= '0;
            timeout_err <= 1'b0;
            burst_cnt   <= '0;
            timeout_cnt <= '0;
        end else begin
            timer <= timer + CNT_WIDTH'(1);
            if (abort) begin
                // Abort wins over everything; burst_cnt is left as-is for the host.
                state <= IDLE;
                timer <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        timer <= '0;
                        if (start) begin
                            state       <= ARM;
                            nb_q        <= nbursts;
                            cap_q       <= capture_len;
                            to_q        <= timeout_len;
                            burst_cnt   <= '0;
                            timeout_err <= 1'b0;
                        end
                    end
                    ARM: begin
                        state <= SEARCH;
                        timer <= '0;
                    end
                    SEARCH: begin
                        // Sync seen on the expiry cycle still counts as found.
                        if (rx_state_in == RX_SYNC) begin
                            state <= LOCK;
                            timer <= '0;
                        end else if (to_hit) begin
                            state       <= GAP;
                            timer       <= '0;
                            timeout_err <= 1'b1;
                            if (timeout_cnt != '1)
                                timeout_cnt <= timeout_cnt + TERR_WIDTH'(1);
                        end
                    end
                    LOCK: begin
                        if (rx_state_in == RX_LOC_RX) begin
                            state <= CAPTURE;
                            timer <= '0;
                        end else if (rx_state_in == RX_INIT) begin
                            state <= GAP;
                            timer <= '0;
                        end
                    end
                    CAPTURE: begin
                        // An early controller drop still closes out a counted burst.
                        if (timer == cap_last || rx_state_in == RX_INIT) begin
                            state     <= GAP;
                            timer     <= '0;
                            burst_cnt <= burst_cnt + BURST_WIDTH'(1);
                        end
                    end
                    GAP: begin
                        if (gap_end) begin
                            state <= seq_fin ? IDLE : ARM;
                            timer <= '0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/tag_rx_sched.md
# tag_rx_sched

Burst scheduler for the tag receive chain. It owns the `run_rx` enable of the tag RX controller and sequences a programmed number of localization bursts. Each burst is: arm, search for preamble, wait for the sync lock to complete, capture baseband for a fixed window, then hold the controller in clear for a guard gap. The block sits between the host settings registers and the RX controller. It reports progress, completion and preamble-search timeouts back to the host.

## Interface
Parameters:
- `CNT_WIDTH`, 32: width of the capture, timeout and gap timers.
- `BURST_WIDTH`, 8: width of the burst count and burst target.
- `TERR_WIDTH`, 16: width of the saturating timeout-event counter.
- `GAP_LEN`, 1024: guard cycles with `run_rx` low between bursts. Values below 2 are treated as 2.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `start`, in, 1: single-cycle pulse that begins a burst sequence. Ignored while `busy`.
- `abort`, in, 1: single-cycle pulse that returns the block to IDLE from any state.
- `nbursts`, in, BURST_WIDTH: bursts per sequence. 0 means run continuously until `abort`.
- `capture_len`, in, CNT_WIDTH: capture window in cycles. 0 is treated as 1.
- `timeout_len`, in, CNT_WIDTH: preamble-search limit in cycles. 0 disables the timeout.
- `rx_state_in`, in, 2: RX controller state. 00 INIT, 01 LOC_SYNC, 10 RX_START, 11 LOC_RX.
- `run_rx`, out, 1: enable to the RX controller. Low holds the controller in clear.
- `capture_en`, out, 1: high during the capture window; gates the downstream sample writer.
- `busy`, out, 1: high in any state other than IDLE.
- `done`, out, 1: one-cycle pulse when a finite sequence completes.
- `timeout_err`, out, 1: sticky flag. Cleared by `reset` or by an accepted `start`.
- `burst_cnt`, out, BURST_WIDTH: bursts completed in the current sequence.
- `timeout_cnt`, out, TERR_WIDTH: number of search timeouts. Saturates at all-ones. Cleared only by `reset`.

## Operation
- States: IDLE, ARM, SEARCH, LOCK, CAPTURE, GAP. A single cycle timer is cleared on every state entry.
- Output decode from the registered state:
  - `run_rx` is high in ARM, SEARCH, LOCK and CAPTURE.
  - `capture_en` is high in CAPTURE only.
  - `busy` is high whenever the state is not IDLE.
- IDLE:
  - On `start` with no `abort`, go to ARM.
  - Latch `nbursts`, `capture_len` and `timeout_len` into shadow registers.
  - Clear `burst_cnt` and `timeout_err`.
  - Later changes to these inputs do not affect a running sequence.
- ARM: lasts exactly 1 cycle, then SEARCH.
- SEARCH:
  - If `rx_state_in` is 01, go to LOCK.
  - Otherwise, if the timeout is enabled and the timer equals `timeout_len`-1, go to GAP. Set `timeout_err` and increment `timeout_cnt`. No burst is counted.
  - If `rx_state_in` is 01 on the same cycle as timer expiry, the sync wins.
- LOCK:
  - If `rx_state_in` is 11, go to CAPTURE.
  - If `rx_state_in` is 00 (the controller aborted), go to GAP with no burst counted.
- CAPTURE:
  - When the timer reaches `capture_len`-1, increment `burst_cnt` and go to GAP.
  - If `rx_state_in` returns to 00 before that, still increment `burst_cnt` and go to GAP.
- GAP: after `GAP_LEN` cycles, evaluate:
  - If `nbursts` is not 0 and `burst_cnt` equals `nbursts`: pulse `done` and go to IDLE.
  - Otherwise go to ARM.
- `burst_cnt` wraps modulo 2^BURST_WIDTH in continuous mode.
- `abort`:
  - In any non-IDLE state, go to IDLE on the next cycle with no `done` pulse. `burst_cnt` holds its value.
  - `abort` has priority over every other transition, including `start` in IDLE.

## Timing
- Reset values of all outputs are 0 and the state is IDLE.
- `start` sampled at edge t gives `busy` and `run_rx` high from cycle t+1. SEARCH begins at t+2.
- `run_rx` is low for at least `GAP_LEN` (minimum 2) cycles between bursts. This guarantees the controller passes through clear.
- CAPTURE lasts exactly `capture_len` cycles unless it exits early. `capture_en` is continuous over that window.
- The `done` pulse is coincident with the GAP to IDLE transition. `busy` drops on the cycle after `done`.
- `reset` asserted mid-sequence returns everything to reset values on the next edge.

## Test plan
- `nbursts`=2, `capture_len`=8, `GAP_LEN`=4, with a model that drives `rx_state_in` 00→01 after 5 cycles and 01→11 after 10 cycles. Expect two `run_rx` windows, `capture_en` high for 8 cycles each, `burst_cnt` ending at 2, a single `done` pulse, and `busy` low afterwards.
- `timeout_len`=20 with `rx_state_in` stuck at 00. Expect `run_rx` to drop after SEARCH has lasted 20 cycles, `timeout_err`=1, `timeout_cnt` incrementing once per retry, and `burst_cnt`=0.
- `rx_state_in` goes to 01 on the same cycle the timer expires. Expect LOCK to be entered and no timeout recorded.
- `abort` during CAPTURE at timer=3. Expect IDLE next cycle, `run_rx`=0 and `capture_en`=0, no `done`, and `burst_cnt` unchanged.
- `start` pulsed while `busy`, and `nbursts` changed mid-sequence. Expect both to be ignored and the sequence to complete with the originally latched count.
- `nbursts`=0 for 300 bursts. Expect `burst_cnt` to wrap 255→0, no `done`, and the sequence to stop only on `abort`.
